xq2_issue_sched: RTL and testbench
==================================

# xq2_issue_sched

Issue scheduler for the shared xQ2 datapath of the SOML decoder. Round-robin arbitration among NREQ requesters. Each granted request drives one start pulse plus a column-mux select into the fixed-latency xQ2 pipeline (YGB2 → trace → divide). Each xQ2 result is re-associated with the originating requester and tag, buffered in a result queue, and released with a valid/ready handshake. Credit-based flow control means no result is ever lost.

## Interface
- NREQ, 4: number of requesters (2..8)
- TAGW, 4: request tag width
- LAT, 12: cycles from dp_start high to dp_xq2 valid (datapath latency, ≥2)
- II, 4: minimum cycles between consecutive dp_start pulses (≥1)
- RQ_DEPTH, 4: result queue depth; also the issue credit limit (power of 2)
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_tag  in  NREQ*TAGW  tag per requester, requester i at bits [i*TAGW +: TAGW]
- req_ready  out  NREQ  one-hot grant; handshake is req_valid[i] & req_ready[i]
- dp_start  out  1  one-cycle start pulse to the xQ2 datapath
- dp_sel  out  $clog2(NREQ)  column-mux select, valid while dp_start is high
- dp_xq2  in  16  xQ2 result, Q8.8, sampled LAT cycles after dp_start
- res_valid  out  1  result queue head valid
- res_ready  in  1  consumer accepts head
- res_src  out  $clog2(NREQ)  requester index of head
- res_tag  out  TAGW  tag of head
- res_data  out  16  xQ2 value of head
- flush  in  1  synchronous flush of all in-flight work and queued results
- busy  out  1  high while any work is in flight or queued

## Operation
- The FSM has three states.
  - IDLE: req_ready is driven from the arbiter when credit is available; on a handshake go to ISSUE.
  - ISSUE: one cycle; dp_start=1, dp_sel=granted index; then go to GAP if II>1, else back to IDLE.
  - GAP: count II-1 cycles from the dp_start cycle, then go to IDLE.
- Credit: credit_used = inflight + queue occupancy. req_ready is all-zero when credit_used ≥ RQ_DEPTH or when the FSM is not in IDLE.
- Arbitration is round-robin. The pointer advances to (granted+1) mod NREQ only on a handshake. With no handshake the pointer holds.
- At most one req_ready bit is high. It is combinational from req_valid, the pointer and the credit state.
- Tracking: a LAT-stage shift register carries {valid, src, tag} from the dp_start cycle. On stage LAT valid, dp_xq2 is written into the queue with that src and tag.
- The result queue is a FIFO. The head drives res_*. Pop happens on res_valid & res_ready. A push and a pop in the same cycle are both performed, and occupancy is unchanged.
- Credit accounting:
  - An issue increments inflight.
  - A write-back decrements inflight and increments queue occupancy.
  - A pop frees one credit.
  - Simultaneous events are summed within the cycle.
- flush has priority over every other event. It clears all tracker valid bits, empties the queue, returns the FSM to IDLE and zeroes the credits. The round-robin pointer is kept. req_ready is 0 in the flush cycle.
- busy = (credit_used != 0) | (state != IDLE).

## Timing
- Reset values: req_ready=0, dp_start=0, dp_sel=0, res_valid=0, res_src=0, res_tag=0, res_data=0, busy=0. FSM=IDLE, pointer=0, tracker and queue empty.
- Handshake in cycle T: dp_start is high in T+1.
- dp_xq2 is sampled in T+1+LAT, and res_valid rises in T+2+LAT.
- Issue throughput is one request per max(II,2) cycles.
- Reset asserted mid-operation drops all in-flight and queued work immediately. No result for that work appears after reset is released.
- res_* are stable while res_valid & !res_ready.

## Configuration
- XQ2_SCHED_PERF_EN defined: adds two outputs.
  - perf_issue (32 bits): counts dp_start pulses.
  - perf_stall (32 bits): counts cycles with |req_valid and no handshake.
  - Both reset to 0, wrap on overflow and are not cleared by flush.
- Undefined: neither port nor either counter exists.

## Structure
- Shared package soml_pkg holds:
  - the Q8.8 width constant XQ_W=16;
  - the FSM state encoding (IDLE/ISSUE/GAP);
  - the default LAT value matching the xQ2 datapath.
- One sub-module, rr_arbiter: NREQ-wide round-robin with a hold-on-no-grant pointer and a grant-enable input.
- Tracker, queue and FSM live in the top module.

## Test plan
- **Single request.** Reset, then req_valid=4'b0001 with tag 5. Expect dp_start one cycle after the handshake with dp_sel=0. Drive dp_xq2=16'h0180 at stage LAT. Expect res_valid at +LAT+2 with src=0, tag=5, data=16'h0180.
- **Round-robin.** Hold req_valid=4'b1111 continuously with res_ready=1. Expect grants in order 0,1,2,3,0 with dp_start pulses exactly II=4 cycles apart.
- **Backpressure.** Set res_ready=0 and keep requests pending. Expect exactly 4 issues, then req_ready=0 indefinitely. Pulse res_ready for one cycle. Expect exactly one further issue.
- **Simultaneous push/pop.** Queue holds 2 entries, a write-back arrives and res_ready=1 in the same cycle. Occupancy stays at 2 and FIFO order is preserved.
- **Flush with work in flight.** Assert flush while 2 requests are in flight. Expect res_valid=0 afterwards, and no results appear for those requests even when their LAT window elapses. busy=0 in the next cycle.
- **Async reset.** Assert rstn low mid-GAP. All outputs are at their reset values before the next clock edge, and the pointer returns to 0.

Source files
------------

// File: rtl/soml_pkg.sv
// Shared SOML decoder definitions: Q8.8 width,
// xQ2 datapath latency and issue-scheduler state encoding.
package soml_pkg;

  localparam int XQ_W    = 16;
  localparam int XQ2_LAT = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_st_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer moves past the winner
// only when a grant is issued and holds otherwise.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [SW-1:0]   o_idx
);

  localparam int SW1 = SW + 1;

  logic [SW-1:0]   r_ptr;
  logic [NREQ-1:0] w_gnt;
  logic [SW-1:0]   w_idx;
  logic            w_hit;

  // First active requester at or after the pointer wins
  always_comb begin
    logic [SW:0]   w_s;
    logic [SW-1:0] w_j;
    w_gnt = '0;
    w_idx = '0;
    w_hit = 1'b0;
    w_s   = '0;
    w_j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_s = {1'b0, r_ptr} + SW1'(i);
      if (w_s >= SW1'(NREQ))
        w_s = w_s - SW1'(NREQ);
      w_j = w_s[SW-1:0];
      if (!w_hit && i_en && i_req[w_j]) begin
        w_hit      = 1'b1;
        w_gnt[w_j] = 1'b1;
        w_idx      = w_j;
      end
    end
  end

  // Advance past the winner on a grant only
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_ptr <= '0;
    else if (w_hit)
      r_ptr <= (w_idx == SW'(NREQ - 1)) ?
               '0 : w_idx + SW'(1);
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;

endmodule

// File: rtl/xq2_issue_sched.sv
// xQ2 issue scheduler: RR issue, latency tracker, result FIFO.
// Optional XQ2_SCHED_PERF_EN adds perf_issue/perf_stall counters.
module xq2_issue_sched
  import soml_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TAGW     = 4,
  parameter int LAT      = XQ2_LAT,
  parameter int II       = 4,
  parameter int RQ_DEPTH = 4,
  parameter int SW       = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]     req_ready,
  output logic                dp_start,
  output logic [SW-1:0]       dp_sel,
  input  logic [XQ_W-1:0]     dp_xq2,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [SW-1:0]       res_src,
  output logic [TAGW-1:0]     res_tag,
  output logic [XQ_W-1:0]     res_data,
  input  logic                flush,
  output logic                busy
`ifdef XQ2_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_issue,
  output logic [31:0]         perf_stall
`endif
);

  localparam int AW  = $clog2(RQ_DEPTH);
  localparam int CW  = AW + 1;
  localparam int GW  = (II > 2) ? $clog2(II) : 1;
  localparam int GLD = (II > 2) ? II - 3 : 0;

  sched_st_e       r_st;
  logic [GW-1:0]   r_gap;
  logic            r_start;
  logic [SW-1:0]   r_sel;
  logic [TAGW-1:0] r_tag;
  logic [CW-1:0]   r_infl;
  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   w_credit;
  logic            w_en, w_hs, w_wb;
  logic            w_push, w_pop;
  logic [NREQ-1:0] w_gnt;
  logic [SW-1:0]   w_idx;

  logic [LAT-1:0]  r_tv;
  logic [SW-1:0]   r_ts [LAT];
  logic [TAGW-1:0] r_tt [LAT];

  logic [XQ_W-1:0] r_qd [RQ_DEPTH];
  logic [SW-1:0]   r_qs [RQ_DEPTH];
  logic [TAGW-1:0] r_qt [RQ_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;

  assign w_credit = r_infl + r_occ;
  assign w_en = rstn & ~flush &
                (r_st == ST_IDLE) &
                (w_credit < CW'(RQ_DEPTH));

  rr_arbiter #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .i_req (req_valid),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_hs   = |(req_valid & w_gnt);
  assign w_wb   = r_tv[LAT-1];
  assign w_push = w_wb & ~flush;
  assign w_pop  = res_valid & res_ready & ~flush;

  // Issue sequencing: handshake, start pulse, spacing gap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st    <= ST_IDLE;
      r_gap   <= '0;
      r_start <= 1'b0;
      r_sel   <= '0;
      r_tag   <= '0;
    end else if (flush) begin
      r_st    <= ST_IDLE;
      r_gap   <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_hs;
      unique case (r_st)
        ST_IDLE: begin
          if (w_hs) begin
            r_st  <= ST_ISSUE;
            r_sel <= w_idx;
            r_tag <= req_tag[w_idx*TAGW +: TAGW];
          end
        end
        ST_ISSUE: begin
          r_gap <= GW'(GLD);
          r_st  <= (II > 2) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (r_gap == '0)
            r_st <= ST_IDLE;
          else
            r_gap <= r_gap - GW'(1);
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  // Tracker valid bits follow each start pulse down the pipe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_tv <= '0;
    else if (flush)
      r_tv <= '0;
    else
      r_tv <= {r_tv[LAT-2:0], r_start};
  end

  // Tracker src/tag payload travels alongside the valid bits
  always_ff @(posedge clk) begin
    r_ts[0] <= r_sel;
    r_tt[0] <= r_tag;
    for (int k = 1; k < LAT; k++) begin
      r_ts[k] <= r_ts[k-1];
      r_tt[k] <= r_tt[k-1];
    end
  end

  // Credits and FIFO pointers; flush drops everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_infl <= '0;
      r_occ  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else if (flush) begin
      r_infl <= '0;
      r_occ  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      r_infl <= r_infl + CW'(w_hs) - CW'(w_wb);
      r_occ  <= r_occ + CW'(w_push) - CW'(w_pop);
      r_wp   <= r_wp + AW'(w_push);
      r_rp   <= r_rp + AW'(w_pop);
    end
  end

  // Result storage written on write-back
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qd[r_wp] <= dp_xq2;
      r_qs[r_wp] <= r_ts[LAT-1];
      r_qt[r_wp] <= r_tt[LAT-1];
    end
  end

  assign dp_start  = r_start;
  assign dp_sel    = r_sel;
  assign res_valid = (r_occ != '0);
  assign res_src   = res_valid ? r_qs[r_rp] : '0;
  assign res_tag   = res_valid ? r_qt[r_rp] : '0;
  assign res_data  = res_valid ? r_qd[r_rp] : '0;
  assign busy      = (w_credit != '0) |
                     (r_st != ST_IDLE);

`ifdef XQ2_SCHED_PERF_EN
  logic [31:0] r_pi, r_ps;

  // Issue and stall counters survive flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pi <= '0;
      r_ps <= '0;
    end else begin
      r_pi <= r_pi + 32'(r_start);
      r_ps <= r_ps + 32'(|req_valid && !w_hs);
    end
  end

  assign perf_issue = r_pi;
  assign perf_stall = r_ps;
`endif

endmodule

// File: tb/tb_xq2_issue_sched.sv
// Bench for xq2_issue_sched: directed phases plus random traffic
// against a transaction-level model of issue, credit and results.
module tb_xq2_issue_sched;

  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int LAT  = 12;
  localparam int II   = 4;
  localparam int RQD  = 4;
  localparam int GAPC = (II > 2) ? II : 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_tag = '0;
  logic [3:0]  req_ready;
  logic        dp_start;
  logic [1:0]  dp_sel;
  logic [15:0] dp_xq2 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_src;
  logic [3:0]  res_tag;
  logic [15:0] res_data;
  logic        flush = 1'b0;
  logic        busy;
`ifdef XQ2_SCHED_PERF_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  xq2_issue_sched #(
    .NREQ     (NREQ),
    .TAGW     (TAGW),
    .LAT      (LAT),
    .II       (II),
    .RQ_DEPTH (RQD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .dp_start  (dp_start),
    .dp_sel    (dp_sel),
    .dp_xq2    (dp_xq2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_src   (res_src),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .flush     (flush),
    .busy      (busy)
`ifdef XQ2_SCHED_PERF_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  typedef struct {
    int src;
    int tag;
    int data;
    int hs;
  } rec_t;

  // Issued requests whose result has not been consumed, oldest first
  rec_t pend[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ptr = 0;
  int last_hs = -100;
  int last_src = 0;
  int n_start = 0;
  int n_pop = 0;
  logic        use_fix = 1'b0;
  logic [15:0] fix_data = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0]  rv,
                      input logic        rr,
                      input logic        fl,
                      input logic [15:0] tg);
    logic [3:0] eg;
    logic       ev;
    logic       eb;
    int         gi;
    int         d;
    rec_t       r;
    @(posedge clk);
    #1;
    cyc++;
    req_valid = rv;
    req_tag   = tg;
    res_ready = rr;
    flush     = fl;
    dp_xq2    = 16'($urandom);
    foreach (pend[k])
      if (pend[k].hs + 1 + LAT == cyc)
        dp_xq2 = 16'(pend[k].data);
    #1;
    eg = '0;
    gi = -1;
    if (!fl && cyc - last_hs >= GAPC &&
        pend.size() < RQD)
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (ptr + i) % NREQ;
        if (gi < 0 && rv[j]) gi = j;
      end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("dp_start", 32'(dp_start),
        32'(cyc == last_hs + 1));
    if (cyc == last_hs + 1)
      chk("dp_sel", 32'(dp_sel), 32'(last_src));
    ev = pend.size() > 0 &&
         cyc >= pend[0].hs + 2 + LAT;
    chk("res_valid", 32'(res_valid), 32'(ev));
    if (ev) begin
      chk("res_src", 32'(res_src), 32'(pend[0].src));
      chk("res_tag", 32'(res_tag), 32'(pend[0].tag));
      chk("res_data", 32'(res_data),
          32'(pend[0].data));
    end
    eb = pend.size() != 0 ||
         (cyc - last_hs >= 1 && cyc - last_hs < GAPC);
    chk("busy", 32'(busy), 32'(eb));
    if (dp_start === 1'b1) n_start++;
    if (res_valid === 1'b1 && rr && !fl) n_pop++;
    if (fl) begin
      pend.delete();
      last_hs = -100;
    end else begin
      if (ev && rr) void'(pend.pop_front());
      if (gi >= 0) begin
        d = use_fix ? int'(fix_data)
                    : int'($urandom_range(0, 65535));
        r.src  = gi;
        r.tag  = int'(tg[gi*TAGW +: TAGW]);
        r.data = d;
        r.hs   = cyc;
        pend.push_back(r);
        ptr      = (gi + 1) % NREQ;
        last_hs  = cyc;
        last_src = gi;
        use_fix  = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++)
      step(4'b0000, rr, 1'b0, 16'($urandom));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_start"}, 32'(dp_start), 0);
    chk({tag, "_sel"}, 32'(dp_sel), 0);
    chk({tag, "_rvalid"}, 32'(res_valid), 0);
    chk({tag, "_rsrc"}, 32'(res_src), 0);
    chk({tag, "_rtag"}, 32'(res_tag), 0);
    chk({tag, "_rdata"}, 32'(res_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    req_valid = 4'b1111;
    @(posedge clk);
    #1;
    cyc++;
    chk_reset_outs("rst0");
    req_valid = '0;
    @(posedge clk);
    #1;
    cyc++;
    rstn = 1'b1;

    // Single request, tag 5, data 0x0180
    use_fix  = 1'b1;
    fix_data = 16'h0180;
    step(4'b0001, 1'b1, 1'b0, 16'h0005);
    idle(LAT + 4, 1'b1);

    // Round-robin with all requesters active
    for (int i = 0; i < 24; i++)
      step(4'b1111, 1'b1, 1'b0, 16'($urandom));
    idle(30, 1'b1);

    // Backpressure: credits run out after four issues
    n_start = 0;
    for (int i = 0; i < 40; i++)
      step(4'b1111, 1'b0, 1'b0, 16'($urandom));
    chk("bp_issues", 32'(n_start), 4);
    n_start = 0;
    step(4'b1111, 1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 30; i++)
      step(4'b1111, 1'b0, 1'b0, 16'($urandom));
    chk("bp_more", 32'(n_start), 1);
    idle(30, 1'b1);

    // Push and pop in the same cycle with two queued
    step(4'b0100, 1'b0, 1'b0, 16'($urandom));
    idle(3, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 16'($urandom));
    idle(3, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 16'($urandom));
    idle(12, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 16'($urandom));
    n_pop = 0;
    idle(10, 1'b1);
    chk("pp_occ", 32'(n_pop), 2);

    // Flush with two requests in flight
    step(4'b0011, 1'b1, 1'b0, 16'($urandom));
    idle(3, 1'b1);
    step(4'b0011, 1'b1, 1'b0, 16'($urandom));
    idle(2, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 16'($urandom));
    n_pop = 0;
    idle(LAT + 6, 1'b1);
    chk("flush_pop", 32'(n_pop), 0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(4'($urandom),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) < 3,
           16'($urandom));
    idle(30, 1'b1);

    // Asynchronous reset while in the gap after an issue
    step(4'b1111, 1'b0, 1'b0, 16'($urandom));
    idle(3, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 16'($urandom));
    idle(2, 1'b0);
    req_valid = 4'b1111;
    #1;
    rstn = 1'b0;
    #1;
    chk_reset_outs("arst");
    pend.delete();
    ptr = 0;
    last_hs = -100;
    @(posedge clk);
    #1;
    cyc++;
    chk_reset_outs("arst_hold");
    req_valid = '0;
    #1;
    rstn = 1'b1;
    step(4'b1111, 1'b1, 1'b0, 16'($urandom));
    idle(LAT + 6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
